spram_be_clr: RTL and testbench
===============================

// Module: spram_be_clr
// PURPOSE
//  Parametrised single-port synchronous RAM for the dcache data/tag arrays; successor to the fixed 512x32 RAM.
//  Adds byte-lane write enables, a per-access valid handshake and a hardware clear engine.
//  The clear engine zeroes every word after reset or on request, so the cache starts with known contents.
//  Sits between the dcache controller and the storage array; one access per cycle when ready.
// PARAMETERS
//  ADDR_W   9   address width; depth = 2**ADDR_W words
//  DATA_W   32  word width; must be a multiple of 8
//  CLR_VAL  0   DATA_W-bit value written to every word by the clear engine
// PORTS
//  clk            in   1         rising-edge clock
//  reset_n        in   1         asynchronous reset, active-low
//  req            in   1         access request, sampled on clk
//  we             in   1         1 = write, 0 = read (qualified by req)
//  byteen         in   DATA_W/8  byte-lane write enables (bit i covers datain[8i+7:8i])
//  addr           in   ADDR_W    word address
//  datain         in   DATA_W    write data
//  clear          in   1         pulse: start a full clear of the array
//  ready          out  1         1 = accesses accepted; 0 = clear in progress
//  dataout        out  DATA_W    read data / write-through data
//  dataout_valid  out  1         1-cycle pulse, dataout holds the result of an accepted req
// BEHAVIOUR
//  - Reset (reset_n=0, async): ready=0, dataout=0, dataout_valid=0, clear counter=0, FSM=CLEAR.
//    The array itself is not reset asynchronously; the clear engine initialises it.
//  - FSM states: CLEAR, READY.
//    CLEAR: each cycle writes CLR_VAL to mem[cnt], cnt++.
//      After the write to cnt = 2**ADDR_W-1 -> READY, cnt returns to 0.
//      Clear duration is exactly 2**ADDR_W cycles from reset release.
//    READY: ready=1; clear=1 -> CLEAR next cycle (cnt=0).
//  - req with ready=0 is ignored: no write, no dataout_valid.
//    req and clear asserted together in READY: clear wins and req is dropped.
//  - clear asserted while in CLEAR is ignored; the count does not restart.
//  - reset_n asserted mid-clear aborts immediately; the clear restarts from word 0 after release.
//  - Accepted read (req=1, we=0): next cycle dataout=mem[addr], dataout_valid=1.
//  - Accepted write (req=1, we=1):
//    - Per lane i, mem[addr] lane i = byteen[i] ? datain lane : old lane.
//    - Next cycle dataout = merged word (write-through), dataout_valid=1.
//    - byteen=0 performs a read-like access: no change, dataout=old word.
//  - No accepted req: dataout holds its previous value; dataout_valid=0.
//  - Latency 1 cycle (base); back-to-back accesses to the same address see the prior write.
//  - Addresses always in range (2**ADDR_W words), no wrap logic needed beyond the clear counter.
// CONFIGURATION
//  SPRAM_OUTREG_EN defined:
//    - Extra output register stage; dataout/dataout_valid delayed 1 more cycle (latency 2).
//    - The stage resets to 0 and is flushed (valid=0) when CLEAR is entered.
//  SPRAM_OUTREG_EN undefined: latency 1 as above.
//  Array contents and the handshake are identical in both builds.
// TESTING (ADDR_W=4, DATA_W=32 bench; depth 16)
//  1 Release reset_n -> ready=0 for exactly 16 cycles then 1; reads of all 16 words return 0, valid pulse each.
//  2 Write addr 3 = 32'hDEADBEEF, byteen=4'hF; then write byteen=4'b0010, datain=32'h0000_5500
//    -> second dataout = 32'hDEAD55EF; read addr 3 -> 32'hDEAD55EF.
//  3 req=1 during clear (ready=0), write addr 5 = 32'h1234 -> no valid pulse;
//    read addr 5 after ready -> 0.
//  4 In READY, assert clear and req (write addr 7) together -> write dropped, ready=0 for 16 cycles,
//    then all words read 0.
//  5 Drop reset_n at clear cycle 8 -> outputs 0 at once; after release ready stays 0 a full 16 cycles.
//  6 Build with SPRAM_OUTREG_EN: repeat test 2 -> dataout_valid arrives 2 cycles after req, same data.

Source files
------------

// File: rtl/spram_be_clr.sv
// Single-port synchronous RAM with byte-lane writes, valid handshake and a hardware clear engine.
// Optional build macro SPRAM_OUTREG_EN adds a second output register stage (latency 2).
module spram_be_clr #(
  parameter int                ADDR_W  = 9,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] byteen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   datain,
  input  logic                clear,
  output logic                ready,
  output logic [DATA_W-1:0]   dataout,
  output logic                dataout_valid
);

  localparam int NLANE = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_dout1;
  logic                r_valid1;
  logic                w_accept;
  logic                w_cnt_last;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_result;

  // A simultaneous clear request takes priority, so the access is dropped.
  assign w_accept   = req && (r_state == S_READY) && !clear;
  assign w_cnt_last = (r_cnt == {ADDR_W{1'b1}});
  assign w_old      = r_mem[addr];
  assign w_result   = we ? w_merged : w_old;

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NLANE; i++) begin
      if (byteen[i]) w_merged[8*i +: 8] = datain[8*i +: 8];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (w_cnt_last) w_state_next = S_READY;
      S_READY: if (clear)      w_state_next = S_CLEAR;
      default:                 w_state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + ADDR_W'(1);
      else                    r_cnt <= '0;
    end
  end

  // Storage has no reset; the clear engine provides known contents.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)   r_mem[r_cnt] <= CLR_VAL;
    else if (w_accept && we)  r_mem[addr]  <= w_merged;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout1  <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= w_accept;
      if (w_accept) r_dout1 <= w_result;
    end
  end

  assign ready = (r_state == S_READY);

`ifdef SPRAM_OUTREG_EN
  logic              w_flush;
  logic [DATA_W-1:0] r_dout2;
  logic              r_valid2;

  // Any result still in flight is discarded when a clear begins.
  assign w_flush = (r_state == S_CLEAR) || clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout2  <= '0;
      r_valid2 <= 1'b0;
    end else begin
      r_valid2 <= r_valid1 && !w_flush;
      if (r_valid1 && !w_flush) r_dout2 <= r_dout1;
    end
  end

  assign dataout       = r_dout2;
  assign dataout_valid = r_valid2;
`else
  assign dataout       = r_dout1;
  assign dataout_valid = r_valid1;
`endif

endmodule

// File: tb/tb_spram_be_clr.sv
// Self-checking bench for spram_be_clr (ADDR_W=4, DATA_W=32) against a word/byte array model.
module tb_spram_be_clr;

`ifdef SPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we, clear;
  logic [3:0]  byteen;
  logic [3:0]  addr;
  logic [31:0] datain;
  logic        ready;
  logic [31:0] dataout;
  logic        dataout_valid;

  int          nChecks = 0;
  int          nFail   = 0;
  logic [31:0] modelMem [DEPTH];

  spram_be_clr #(.ADDR_W(4), .DATA_W(32), .CLR_VAL(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byteen(byteen),
    .addr(addr), .datain(datain), .clear(clear), .ready(ready),
    .dataout(dataout), .dataout_valid(dataout_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [3:0] be,
                                             input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  // Single access; early flags a valid pulse seen before the expected latency.
  task automatic doAccess(input logic w, input logic [3:0] be, input logic [3:0] a,
                          input logic [31:0] d, output logic [31:0] dout,
                          output logic vld, output logic early);
    req = 1'b1; we = w; byteen = be; addr = a; datain = d;
    step();
    req = 1'b0; we = 1'b0;
    early = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      if (dataout_valid !== 1'b0) early = 1'b1;
      step();
    end
    dout = dataout;
    vld  = dataout_valid;
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] d;
    logic v, e;
    reset_n = 1'b0; req = 0; we = 0; clear = 0; byteen = 0; addr = 0; datain = 0;
    #23;
    nChecks++; if (ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ready got %b exp 0", ready); end
    nChecks++; if (dataout !== 32'h0) begin nFail++; $display("[TB] FAIL reset_dataout got %h exp 0", dataout); end
    nChecks++; if (dataout_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid got %b exp 0", dataout_valid); end
    @(posedge clk); #1 reset_n = 1'b1;
    waitReady(n);
    nChecks++; if (n != 16) begin nFail++; $display("[TB] FAIL reset_clear_len got %0d exp 16", n); end
    modelClear();
    for (int i = 0; i < DEPTH; i++) begin
      doAccess(1'b0, 4'h0, 4'(i), 32'h0, d, v, e);
      nChecks++;
      if (d !== 32'h0 || v !== 1'b1 || e !== 1'b0) begin
        nFail++; $display("[TB] FAIL reset_read[%0d] got %h v%b e%b exp 0 v1 e0", i, d, v, e);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic v, e;
    doAccess(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, d, v, e);
    modelMem[3] = 32'hDEADBEEF;
    nChecks++; if (d !== 32'hDEADBEEF || v !== 1'b1 || e !== 1'b0) begin
      nFail++; $display("[TB] FAIL bl_full_write got %h v%b e%b exp DEADBEEF v1 e0", d, v, e); end
    doAccess(1'b1, 4'b0010, 4'd3, 32'h0000_5500, d, v, e);
    modelMem[3] = modelMerge(modelMem[3], 4'b0010, 32'h0000_5500);
    nChecks++; if (d !== 32'hDEAD55EF || v !== 1'b1 || e !== 1'b0) begin
      nFail++; $display("[TB] FAIL bl_lane1_write got %h v%b e%b exp DEAD55EF v1 e0", d, v, e); end
    doAccess(1'b0, 4'h0, 4'd3, 32'h0, d, v, e);
    nChecks++; if (d !== 32'hDEAD55EF || v !== 1'b1) begin
      nFail++; $display("[TB] FAIL bl_readback got %h v%b exp DEAD55EF v1", d, v); end
    doAccess(1'b1, 4'h0, 4'd3, 32'hFFFF_FFFF, d, v, e);
    nChecks++; if (d !== 32'hDEAD55EF || v !== 1'b1) begin
      nFail++; $display("[TB] FAIL bl_zero_be got %h v%b exp DEAD55EF v1", d, v); end
  endtask

  task automatic test_req_during_clear();
    int n;
    logic seen;
    logic [31:0] d;
    logic v, e;
    clear = 1'b1;
    step();
    clear = 1'b0;
    nChecks++; if (ready !== 1'b0) begin nFail++; $display("[TB] FAIL rdc_ready got %b exp 0", ready); end
    n = 0; seen = 1'b0;
    for (int k = 0; k < 3; k++) begin step(); n++; if (dataout_valid) seen = 1'b1; end
    req = 1'b1; we = 1'b1; addr = 4'd5; byteen = 4'hF; datain = 32'h1234; clear = 1'b1;
    step(); n++; if (dataout_valid) seen = 1'b1;
    req = 1'b0; we = 1'b0; clear = 1'b0;
    while (ready !== 1'b1 && n < 100) begin
      step(); n++;
      if (dataout_valid) seen = 1'b1;
    end
    modelClear();
    nChecks++; if (n != 16) begin nFail++; $display("[TB] FAIL rdc_clear_len got %0d exp 16", n); end
    nChecks++; if (seen !== 1'b0) begin nFail++; $display("[TB] FAIL rdc_no_valid got %b exp 0", seen); end
    doAccess(1'b0, 4'h0, 4'd5, 32'h0, d, v, e);
    nChecks++; if (d !== 32'h0 || v !== 1'b1) begin
      nFail++; $display("[TB] FAIL rdc_read5 got %h v%b exp 0 v1", d, v); end
  endtask

  task automatic test_clear_with_req();
    int n;
    logic seen;
    logic [31:0] d;
    logic v, e;
    doAccess(1'b1, 4'hF, 4'd7, 32'hAAAA5555, d, v, e);
    nChecks++; if (d !== 32'hAAAA5555 || v !== 1'b1) begin
      nFail++; $display("[TB] FAIL cwr_prewrite got %h v%b exp AAAA5555 v1", d, v); end
    req = 1'b1; we = 1'b1; addr = 4'd7; byteen = 4'hF; datain = 32'h7777_7777; clear = 1'b1;
    step();
    req = 1'b0; we = 1'b0; clear = 1'b0;
    seen = dataout_valid; n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step(); n++;
      if (dataout_valid) seen = 1'b1;
    end
    modelClear();
    nChecks++; if (n != 16) begin nFail++; $display("[TB] FAIL cwr_clear_len got %0d exp 16", n); end
    nChecks++; if (seen !== 1'b0) begin nFail++; $display("[TB] FAIL cwr_dropped got valid %b exp 0", seen); end
    for (int i = 0; i < DEPTH; i++) begin
      doAccess(1'b0, 4'h0, 4'(i), 32'h0, d, v, e);
      nChecks++;
      if (d !== modelMem[i] || v !== 1'b1) begin
        nFail++; $display("[TB] FAIL cwr_read[%0d] got %h v%b exp %h v1", i, d, v, modelMem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [31:0] d;
    logic v, e;
    doAccess(1'b1, 4'hF, 4'd2, 32'hCAFEF00D, d, v, e);
    nChecks++; if (d !== 32'hCAFEF00D || v !== 1'b1) begin
      nFail++; $display("[TB] FAIL rmc_prewrite got %h v%b exp CAFEF00D v1", d, v); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 8; k++) step();
    reset_n = 1'b0;
    #1;
    nChecks++; if (ready !== 1'b0 || dataout !== 32'h0 || dataout_valid !== 1'b0) begin
      nFail++; $display("[TB] FAIL rmc_async got r%b d%h v%b exp r0 d0 v0", ready, dataout, dataout_valid); end
    step(); step();
    reset_n = 1'b1;
    waitReady(n);
    modelClear();
    nChecks++; if (n != 16) begin nFail++; $display("[TB] FAIL rmc_clear_len got %0d exp 16", n); end
    doAccess(1'b0, 4'h0, 4'd2, 32'h0, d, v, e);
    nChecks++; if (d !== 32'h0 || v !== 1'b1) begin
      nFail++; $display("[TB] FAIL rmc_read2 got %h v%b exp 0 v1", d, v); end
  endtask

  task automatic test_random();
    logic [31:0] d, expD;
    logic v, e, w;
    logic [3:0] be, a;
    logic [31:0] wd;
    for (int i = 0; i < 120; i++) begin
      w  = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (w) modelMem[a] = modelMerge(modelMem[a], be, wd);
      expD = modelMem[a];
      doAccess(w, be, a, wd, d, v, e);
      nChecks++;
      if (d !== expD || v !== 1'b1 || e !== 1'b0) begin
        nFail++; $display("[TB] FAIL rnd[%0d] we%b be%h a%0d got %h v%b e%b exp %h", i, w, be, a, d, v, e, expD);
      end
      if (i % 4 == 3) begin
        step();
        nChecks++;
        if (dataout_valid !== 1'b0 || dataout !== expD) begin
          nFail++; $display("[TB] FAIL rnd_idle[%0d] got %h v%b exp %h v0", i, dataout, dataout_valid, expD);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    logic [31:0] expQ [N];
    logic w;
    logic [3:0] be, a;
    logic [31:0] wd;
    int j;
    for (int c = 0; c < N + LAT - 1; c++) begin
      if (c < N) begin
        w  = 1'($urandom_range(0, 1));
        be = 4'($urandom_range(0, 15));
        a  = 4'($urandom_range(0, 3));
        wd = $urandom;
        if (w) modelMem[a] = modelMerge(modelMem[a], be, wd);
        expQ[c] = modelMem[a];
        req = 1'b1; we = w; byteen = be; addr = a; datain = wd;
      end else begin
        req = 1'b0; we = 1'b0;
      end
      step();
      j = c - (LAT - 1);
      if (j >= 0) begin
        nChecks++;
        if (dataout !== expQ[j] || dataout_valid !== 1'b1) begin
          nFail++; $display("[TB] FAIL b2b[%0d] got %h v%b exp %h v1", j, dataout, dataout_valid, expQ[j]);
        end
      end
    end
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_req_during_clear();
    test_clear_with_req();
    test_reset_mid_clear();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
